// File: rtl/input_dispatcher.sv
// Routes a tile of AXI-Stream beats lane by lane into the input buffer array, then drives
// the drain read enables. Optional element half-swap: define INPUT_DISPATCH_HALFSWAP_EN.
module input_dispatcher #(
  parameter int LANES     = 32,
  parameter int ROW_WORDS = 7,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
`ifdef INPUT_DISPATCH_HALFSWAP_EN
  input  logic              half_swap,
`endif
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic [LANES-1:0]  lane_wr_en,
  output logic [DATA_W-1:0] lane_wr_data,
  output logic [LANES-1:0]  lane_rd_en,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              err_last
);

  localparam int LANE_W  = $clog2(LANES);
  localparam int WORD_W  = $clog2(ROW_WORDS);
  localparam int DRAIN_W = $clog2(2*ROW_WORDS+1);
  localparam logic [LANE_W-1:0]  LANE_LAST  = LANE_W'(LANES-1);
  localparam logic [WORD_W-1:0]  WORD_LAST  = WORD_W'(ROW_WORDS-1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2*ROW_WORDS-1);
  localparam logic [1:0]         SETTLE     = 2'd2;

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("input_dispatcher: DATA_W must be 32");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t              state;
  logic [LANE_W-1:0]   lane_idx;
  logic [WORD_W-1:0]   word_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic [1:0]          settle_cnt;
  logic                beat_ok;
  logic                final_beat;
  logic                rd_ok;
  logic [DATA_W-1:0]   wr_data_next;

  assign s_tready   = (state == LOAD);
  assign beat_ok    = s_tvalid && s_tready;
  assign final_beat = (lane_idx == LANE_LAST) && (word_cnt == WORD_LAST);

  // Reads wait until the last lane write has had two cycles to land in its buffer.
  assign rd_ok      = (state == DRAIN) && (settle_cnt == SETTLE) && rd_ready;
  assign lane_rd_en = {LANES{rd_ok}};

`ifdef INPUT_DISPATCH_HALFSWAP_EN
  logic swap_q;
  assign wr_data_next = swap_q ? {s_tdata[15:0], s_tdata[31:16]} : s_tdata;
`else
  assign wr_data_next = s_tdata;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      lane_idx     <= '0;
      word_cnt     <= '0;
      drain_cnt    <= '0;
      settle_cnt   <= '0;
      lane_wr_en   <= '0;
      lane_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_last     <= 1'b0;
`ifdef INPUT_DISPATCH_HALFSWAP_EN
      swap_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking defaults make lane_wr_en and done single-cycle pulses;
      // any branch below that assigns them overrides these values.
      lane_wr_en <= '0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            err_last <= 1'b0;
            lane_idx <= '0;
            word_cnt <= '0;
`ifdef INPUT_DISPATCH_HALFSWAP_EN
            swap_q   <= half_swap;
`endif
          end
        end
        LOAD: begin
          if (beat_ok) begin
            lane_wr_en   <= LANES'(1) << lane_idx;
            lane_wr_data <= wr_data_next;
            // Framing is judged purely by beat count: tlast must coincide with the final beat.
            if (s_tlast != final_beat) err_last <= 1'b1;
            if (final_beat) begin
              state      <= DRAIN;
              lane_idx   <= '0;
              word_cnt   <= '0;
              drain_cnt  <= '0;
              settle_cnt <= '0;
            end else if (word_cnt == WORD_LAST) begin
              word_cnt <= '0;
              lane_idx <= lane_idx + 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (settle_cnt != SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else if (rd_ready) begin
            if (drain_cnt == DRAIN_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_dispatcher.sv
// Self-checking bench for input_dispatcher: randomized tile loads checked against a
// beat-index routing model, drain counting, framing errors, reset abort and element order.
module tb_input_dispatcher;

  localparam int LANES     = 32;
  localparam int ROW_WORDS = 7;
  localparam int TOTAL     = LANES * ROW_WORDS;
`ifdef INPUT_DISPATCH_HALFSWAP_EN
  localparam bit SWAP_BUILD = 1'b1;
`else
  localparam bit SWAP_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic        swap_req = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] lane_wr_en;
  logic [31:0] lane_wr_data;
  logic [31:0] lane_rd_en;
  logic        rd_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  input_dispatcher #(.LANES(LANES), .ROW_WORDS(ROW_WORDS), .DATA_W(32)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .start        (start),
`ifdef INPUT_DISPATCH_HALFSWAP_EN
    .half_swap    (swap_req),
`endif
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .lane_wr_en   (lane_wr_en),
    .lane_wr_data (lane_wr_data),
    .lane_rd_en   (lane_rd_en),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .err_last     (err_last)
  );

  // Starts a tile and offers n_beats beats. Beat k belongs to lane k / ROW_WORDS.
  // data_mode: 0 = beat index, 1 = random, 2 = 0xAAAA5555. A stray start is pulsed at beat 50.
  task automatic do_load(input int n_beats, input int tlast_beat, input bit gaps, input int data_mode);
    int          k = 0;
    int          cyc = 0;
    bit          valid;
    bit          exp_err = 1'b0;
    logic [31:0] data;
    logic [31:0] exp_en = '0;
    logic [31:0] exp_data = '0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || err_last !== 1'b0)
      begin n_errors++; $display("FAIL start_accept: busy=%b err_last=%b, required busy=1 err_last=0", busy, err_last); end
    while (k < n_beats) begin
      valid = !(gaps && (cyc % 3 == 2));
      case (data_mode)
        0:       data = 32'(k);
        1:       data = $urandom;
        default: data = 32'hAAAA5555;
      endcase
      s_tvalid = valid;
      s_tdata  = data;
      s_tlast  = valid && (k == tlast_beat);
      start    = valid && (k == 50);
      @(negedge clk);
      n_checks++;
      if (s_tready !== 1'b1)
        begin n_errors++; $display("FAIL load_tready beat %0d: s_tready=%b, required 1", k, s_tready); end
      if (valid) begin
        exp_en   = 32'd1 << (k / ROW_WORDS);
        exp_data = (SWAP_BUILD && swap_req) ? {data[15:0], data[31:16]} : data;
        exp_err  = exp_err | ((k == tlast_beat) != (k == TOTAL - 1));
        k++;
      end else begin
        exp_en = '0;
      end
      @(posedge clk); #1;
      n_checks++;
      if (lane_wr_en !== exp_en)
        begin n_errors++; $display("FAIL wr_en beat %0d: got %h, required %h", k - 1, lane_wr_en, exp_en); end
      if (exp_en != '0) begin
        n_checks++;
        if (lane_wr_data !== exp_data)
          begin n_errors++; $display("FAIL wr_data beat %0d: got %h, required %h", k - 1, lane_wr_data, exp_data); end
      end
      n_checks++;
      if (err_last !== exp_err || busy !== 1'b1)
        begin n_errors++; $display("FAIL load_status beat %0d: err_last=%b busy=%b, required err_last=%b busy=1", k - 1, err_last, busy, exp_err); end
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    start    = 1'b0;
    if (n_beats == TOTAL) begin
      n_checks++;
      if (s_tready !== 1'b0)
        begin n_errors++; $display("FAIL drain_tready: s_tready=%b after final beat, required 0", s_tready); end
    end
  endtask

  // Called right after a full load, in the cycle carrying the last lane write.
  task automatic do_drain(input bit toggle);
    int rd_cnt = 0;
    bit prev_rd = 1'b0;
    bit finished = 1'b0;
    for (int c = 0; c < 100 && !finished; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      rd_ready = toggle ? (c % 2 == 0) : 1'b1;
      @(negedge clk);
      if (done === 1'b1) begin
        finished = 1'b1;
        n_checks++;
        if (!prev_rd || rd_cnt != 2 * ROW_WORDS || busy !== 1'b0)
          begin n_errors++; $display("FAIL done_timing: reads=%0d prev_rd=%b busy=%b, required 14 reads just before, busy=0", rd_cnt, prev_rd, busy); end
      end else begin
        n_checks++;
        if (busy !== 1'b1)
          begin n_errors++; $display("FAIL busy_drain cycle %0d: busy=%b, required 1", c, busy); end
      end
      n_checks++;
      if ((!rd_ready || c < 2 || finished) && lane_rd_en !== '0)
        begin n_errors++; $display("FAIL rd_en_gate cycle %0d: got %h, required 0", c, lane_rd_en); end
      else if (lane_rd_en !== '0 && lane_rd_en !== '1)
        begin n_errors++; $display("FAIL rd_en_shape cycle %0d: got %h, required all zeros or all ones", c, lane_rd_en); end
      prev_rd = (lane_rd_en === '1);
      if (prev_rd) rd_cnt++;
    end
    n_checks++;
    if (!finished)
      begin n_errors++; $display("FAIL done_timeout: no done pulse within 100 cycles, reads=%0d", rd_cnt); end
    @(posedge clk); #1;
    rd_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || rd_cnt != 2 * ROW_WORDS)
      begin n_errors++; $display("FAIL drain_end: done=%b busy=%b reads=%0d, required done=0 busy=0 reads=14", done, busy, rd_cnt); end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({s_tready, busy, done, err_last} !== 4'b0 || lane_wr_en !== '0 || lane_wr_data !== '0 || lane_rd_en !== '0)
      begin n_errors++; $display("FAIL reset_outputs: tready=%b busy=%b done=%b err=%b wr_en=%h data=%h rd_en=%h, required all 0",
                                 s_tready, busy, done, err_last, lane_wr_en, lane_wr_data, lane_rd_en); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = $urandom;
      rd_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (s_tready !== 1'b0 || lane_wr_en !== '0 || lane_rd_en !== '0 || busy !== 1'b0)
        begin n_errors++; $display("FAIL idle_ignore: tready=%b wr_en=%h rd_en=%h busy=%b, required all 0", s_tready, lane_wr_en, lane_rd_en, busy); end
    end
    s_tvalid = 1'b0;
    rd_ready = 1'b0;
  endtask

  task automatic test_full_load();
    do_load(TOTAL, TOTAL - 1, 1'b0, 0);
    do_drain(1'b1);
  endtask

  task automatic test_tlast_error();
    do_load(TOTAL, 100, 1'b0, 1);
    do_drain(1'b0);
    n_checks++;
    if (err_last !== 1'b1)
      begin n_errors++; $display("FAIL err_sticky: err_last=%b after tile, required 1", err_last); end
  endtask

  task automatic test_gaps();
    do_load(TOTAL, TOTAL - 1, 1'b1, 1);
    do_drain(1'b0);
  endtask

  task automatic test_reset_mid_load();
    do_load(10, -1, 1'b0, 1);
    nrst = 1'b0;
    #1;
    n_checks++;
    if ({s_tready, busy, done, err_last} !== 4'b0 || lane_wr_en !== '0 || lane_wr_data !== '0 || lane_rd_en !== '0)
      begin n_errors++; $display("FAIL reset_mid_load: tready=%b busy=%b done=%b err=%b wr_en=%h data=%h rd_en=%h, required all 0",
                                 s_tready, busy, done, err_last, lane_wr_en, lane_wr_data, lane_rd_en); end
    @(negedge clk);
    nrst = 1'b1;
    do_load(TOTAL, TOTAL - 1, 1'b0, 0);
    do_drain(1'b1);
  endtask

  task automatic test_data_order();
    for (int s = 1; s >= 0; s--) begin
      swap_req = s[0];
      do_load(3, -1, 1'b0, 2);
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
    end
    swap_req = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_ignore();
    test_full_load();
    test_tlast_error();
    test_gaps();
    test_reset_mid_load();
    test_data_order();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
